// File: rtl/epd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// epd_scan_ctrl_if
//
// Purpose
//   Pixel word stream between the upstream waveform/LUT stage and the EPD scan
//   controller. The controller does not stall the upstream stage. When it
//   takes a word it pulses pix_ready for one clk. If pix_valid is low in that
//   clk, the source drivers receive a zero word.
//
// Signals
//   pix_data   [SD_WIDTH]  source word presented by the upstream stage
//   pix_valid  1           pix_data holds a real word
//   pix_ready  1           the controller consumes pix_data on this clk
//
// Modports
//   master  upstream pixel pipeline (drives data/valid, observes ready)
//   slave   epd_scan_ctrl (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface epd_scan_ctrl_if #(
  parameter int SD_WIDTH = 16
);

  logic [SD_WIDTH-1:0] pix_data;
  logic                pix_valid;
  logic                pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );

endinterface : epd_scan_ctrl_if

// File: rtl/epd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// epd_scan_ctrl
//
// Purpose
//   EPD panel scan controller. It produces gate-driver (GD) and source-driver
//   (SD) timing for num_frames frames per start request. It also streams pixel
//   words from the upstream waveform/LUT stage onto the source data bus.
//   Parameters set the panel geometry, the bus width and the clock ratio.
//
//   A free-running divider produces one "tick" every CLK_DIV clks. All
//   scan-phase counters advance only on a tick. The divider MSB is driven out
//   as the source-driver clock. epd_sd is loaded on the tick clk, so each
//   word is stable well before the next rising edge of epd_sdclk.
//
//   Scan phases per frame:
//     START      PRESCAN+1 ticks   SPV / gate start pulse
//     ROW_START  H_FP+1 ticks      latch-enable phase
//     ROW_DATA   H_ACTIVE ticks    one word per tick
//     ROW_END    H_BP+1 ticks      gate clock (CKV) phase
//     GAP        FRAME_GAP ticks   gate outputs disabled between frames
//
// Configuration
//   EPD_SCAN_UNDERRUN_EN  defined: underrun is a sticky flag. It is set when
//                         a word is taken while pix_valid is low. Only rst or
//                         an accepted start clears it.
//                         undefined: underrun is tied low.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   start       in   1-clk request, only sampled in IDLE
//   num_frames  in   [8] frames to scan, latched on start; 0 ignores start
//   pix         if   epd_scan_ctrl_if.slave pixel stream (pix_data/valid/ready)
//   busy        out  high from the accepted start until the return to IDLE
//   frame_done  out  1-clk pulse at the end of each completed frame
//   underrun    out  sticky starvation flag (see Configuration)
//   epd_gdoe    out  gate driver output enable
//   epd_gdclk   out  gate driver shift clock (CKV)
//   epd_gdsp    out  gate driver start pulse (SPV, active low)
//   epd_sdclk   out  source driver clock (free-running divider MSB)
//   epd_sdle    out  source driver latch enable
//   epd_sdoe    out  source driver output enable
//   epd_sdce0   out  source driver chip enable (active low)
//   epd_sd      out  [SD_WIDTH] source data, registered
// ---------------------------------------------------------------------------
module epd_scan_ctrl #(
  parameter int SD_WIDTH  = 16,
  parameter int H_ACTIVE  = 200,
  parameter int V_ACTIVE  = 600,
  parameter int H_FP      = 2,
  parameter int H_BP      = 2,
  parameter int PRESCAN   = 47,
  parameter int FRAME_GAP = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          num_frames,
  epd_scan_ctrl_if.slave      pix,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                epd_gdoe,
  output logic                epd_gdclk,
  output logic                epd_gdsp,
  output logic                epd_sdclk,
  output logic                epd_sdle,
  output logic                epd_sdoe,
  output logic                epd_sdce0,
  output logic [SD_WIDTH-1:0] epd_sd
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The horizontal counter is shared by every phase. It must be wide enough
  // for the longest phase and must have bit 4 for the START decode
  // (PRESCAN >= 16 guarantees that).
  localparam int H_MAX = max2(max2(max2(PRESCAN, H_FP), max2(H_ACTIVE, H_BP)), FRAME_GAP);
  localparam int H_W   = $clog2(H_MAX + 1);
  localparam int V_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ROW_START,
    S_ROW_DATA,
    S_ROW_END,
    S_GAP
  } state_t;

  // -------------------------------------------------------------------------
  // Tick generator. CLK_DIV is a power of two, so the counter wraps naturally.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div;
  logic             tick;

  // NOTE: sequential state uses non-blocking (<=) assignments. All flops then
  // sample the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= div + 1'b1;
  end

  assign tick      = &div;
  assign epd_sdclk = div[DIV_W-1];

  // -------------------------------------------------------------------------
  // Scan FSM: state and counter registers
  // -------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [H_W-1:0] h, h_nxt;
  logic [V_W-1:0] v, v_nxt;
  logic [7:0]     frames_left, frames_nxt;
  logic           start_ok;
  logic           frame_end;

  // Panel control levels decoded from the current phase. They are registered
  // below so the panel pins are glitch-free.
  logic gdoe_d, gdclk_d, gdsp_d, sdle_d, sdoe_d, sdce0_d;

  assign start_ok = (state == S_IDLE) && start && (num_frames != 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      h           <= '0;
      v           <= '0;
      frames_left <= '0;
    end else begin
      state       <= state_nxt;
      h           <= h_nxt;
      v           <= v_nxt;
      frames_left <= frames_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM: next state, counters and panel levels
  // -------------------------------------------------------------------------
  // NOTE: every signal this block drives gets a default first. Any path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    h_nxt      = h;
    v_nxt      = v;
    frames_nxt = frames_left;
    frame_end  = 1'b0;
    gdoe_d     = 1'b1;
    gdclk_d    = 1'b0;
    gdsp_d     = 1'b1;
    sdle_d     = 1'b0;
    sdoe_d     = 1'b0;
    sdce0_d    = 1'b1;

    unique case (state)
      S_IDLE: begin
        gdoe_d = 1'b0;
        if (start_ok) begin
          state_nxt  = S_START;
          h_nxt      = '0;
          v_nxt      = '0;
          frames_nxt = num_frames;
        end
      end

      S_START: begin
        // The SPV pulse is low once h reaches 16. CKV toggles with h[3].
        gdsp_d  = ~h[4];
        gdclk_d = h[3];
        if (tick) begin
          if (h == H_W'(PRESCAN)) begin
            state_nxt = S_ROW_START;
            h_nxt     = '0;
            v_nxt     = '0;
          end else begin
            h_nxt = h + 1'b1;
          end
        end
      end

      S_ROW_START: begin
        gdclk_d = 1'b1;
        sdle_d  = ~h[1];
        if (tick) begin
          if (h == H_W'(H_FP)) begin
            state_nxt = S_ROW_DATA;
            h_nxt     = '0;
          end else begin
            h_nxt = h + 1'b1;
          end
        end
      end

      S_ROW_DATA: begin
        gdclk_d = 1'b1;
        sdoe_d  = 1'b1;
        sdce0_d = 1'b0;
        if (tick) begin
          if (h == H_W'(H_ACTIVE - 1)) begin
            state_nxt = S_ROW_END;
            h_nxt     = '0;
          end else begin
            h_nxt = h + 1'b1;
          end
        end
      end

      S_ROW_END: begin
        gdclk_d = h[1];
        if (tick) begin
          if (h == H_W'(H_BP)) begin
            h_nxt = '0;
            if (v == V_W'(V_ACTIVE - 1)) begin
              state_nxt = S_GAP;
              frame_end = 1'b1;
            end else begin
              state_nxt = S_ROW_START;
              v_nxt     = v + 1'b1;
            end
          end else begin
            h_nxt = h + 1'b1;
          end
        end
      end

      S_GAP: begin
        gdoe_d = 1'b0;
        if (tick) begin
          if (h == H_W'(FRAME_GAP - 1)) begin
            h_nxt      = '0;
            frames_nxt = frames_left - 8'd1;
            state_nxt  = (frames_left == 8'd1) ? S_IDLE : S_START;
          end else begin
            h_nxt = h + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        h_nxt     = '0;
        v_nxt     = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake and status
  // -------------------------------------------------------------------------
  assign pix.pix_ready = (state == S_ROW_DATA) && tick;
  assign busy          = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Registered panel pins, frame pulse and source data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      epd_gdoe   <= 1'b0;
      epd_gdclk  <= 1'b0;
      epd_gdsp   <= 1'b1;
      epd_sdle   <= 1'b0;
      epd_sdoe   <= 1'b0;
      epd_sdce0  <= 1'b1;
      frame_done <= 1'b0;
      epd_sd     <= '0;
    end else begin
      epd_gdoe   <= gdoe_d;
      epd_gdclk  <= gdclk_d;
      epd_gdsp   <= gdsp_d;
      epd_sdle   <= sdle_d;
      epd_sdoe   <= sdoe_d;
      epd_sdce0  <= sdce0_d;
      frame_done <= frame_end;
      // A starved word is driven as zero. The panel never sees stale data.
      if (pix.pix_ready) epd_sd <= pix.pix_valid ? pix.pix_data : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Underrun flag
  // -------------------------------------------------------------------------
`ifdef EPD_SCAN_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (rst)                                 underrun_q <= 1'b0;
    else if (start_ok)                       underrun_q <= 1'b0;
    else if (pix.pix_ready && !pix.pix_valid) underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule : epd_scan_ctrl

// File: tb/tb_epd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_epd_scan_ctrl
//
// Testbench for epd_scan_ctrl. It uses a small panel geometry: 4 words x 3
// rows, PRESCAN 16, FRAME_GAP 8, CLK_DIV 4.
// A vector table lists the start requests and the expected counts for each
// run. Two hand-written sequences cover the mid-frame reset and its recovery.
// The bench samples all outputs on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_epd_scan_ctrl;

  localparam int SD_WIDTH  = 16;
  localparam int H_ACTIVE  = 4;
  localparam int V_ACTIVE  = 3;
  localparam int H_FP      = 2;
  localparam int H_BP      = 2;
  localparam int PRESCAN   = 16;
  localparam int FRAME_GAP = 8;
  localparam int CLK_DIV   = 4;

`ifdef EPD_SCAN_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [7:0]          num_frames = 8'd0;
  logic                busy, frame_done, underrun;
  logic                gdoe, gdclk, gdsp, sdclk, sdle, sdoe, sdce0;
  logic [SD_WIDTH-1:0] epd_sd;

  always #5 clk = ~clk;

  epd_scan_ctrl_if #(.SD_WIDTH(SD_WIDTH)) pix_if ();

  epd_scan_ctrl #(
    .SD_WIDTH (SD_WIDTH),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_FP     (H_FP),
    .H_BP     (H_BP),
    .PRESCAN  (PRESCAN),
    .FRAME_GAP(FRAME_GAP),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_frames(num_frames),
    .pix       (pix_if),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun),
    .epd_gdoe  (gdoe),
    .epd_gdclk (gdclk),
    .epd_gdsp  (gdsp),
    .epd_sdclk (sdclk),
    .epd_sdle  (sdle),
    .epd_sdoe  (sdoe),
    .epd_sdce0 (sdce0),
    .epd_sd    (epd_sd)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},       int'(busy),             0);
    check({tag, "_frame_done"}, int'(frame_done),       0);
    check({tag, "_underrun"},   int'(underrun),         0);
    check({tag, "_pix_ready"},  int'(pix_if.pix_ready), 0);
    check({tag, "_epd_sd"},     int'(epd_sd),           0);
    check({tag, "_gdoe"},       int'(gdoe),             0);
    check({tag, "_gdclk"},      int'(gdclk),            0);
    check({tag, "_gdsp"},       int'(gdsp),             1);
    check({tag, "_sdle"},       int'(sdle),             0);
    check({tag, "_sdoe"},       int'(sdoe),             0);
    check({tag, "_sdce0"},      int'(sdce0),            1);
  endtask

  // Per-run observations
  int n_ready, n_done, n_gap_runs, n_gap_bad, n_sdce_low, n_gdsp_low;
  int n_sdle_high, n_unstable, n_ce_bad;
  bit busy_seen, busy_first, timed_out;

  // One scan request. The data ramp 1,2,3,... advances one word per consumed
  // tick. Word index `drop` is presented with pix_valid low. `extra` issues a
  // second start (num_frames=5) mid-run. rst_at>0 asserts rst right after the
  // rst_at-th consumed word and returns once the reset values are checked.
  task automatic run_scan(input int nf, input int drop, input bit extra,
                          input int rst_at, input int budget);
    int                  idx;
    int                  run;
    int                  exp_word;
    bit                  pending;
    bit                  prev_ready;
    bit                  rst_fired;
    logic [SD_WIDTH-1:0] prev_sd;

    n_ready = 0; n_done = 0; n_gap_runs = 0; n_gap_bad = 0; n_sdce_low = 0;
    n_gdsp_low = 0; n_sdle_high = 0; n_unstable = 0; n_ce_bad = 0;
    busy_seen = 1'b0; timed_out = 1'b1;
    idx = 0; run = 0; exp_word = 0; pending = 1'b0; rst_fired = 1'b0;
    pix_if.pix_data  = SD_WIDTH'(idx + 1);
    pix_if.pix_valid = (idx != drop);

    @(negedge clk);
    start      = 1'b1;
    num_frames = 8'(nf);
    @(negedge clk);
    start      = 1'b0;
    busy_first = busy;
    prev_sd    = epd_sd;
    prev_ready = 1'b0;

    for (int c = 0; c < budget; c++) begin
      if (rst_fired) begin
        check_reset_vals("rst_mid");
        rst       = 1'b0;
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_seen = 1'b1;
      else if (busy_seen) begin
        timed_out = 1'b0;
        break;
      end

      if (extra && c == 300) begin
        start      = 1'b1;
        num_frames = 8'd5;
      end else begin
        start = 1'b0;
      end

      // epd_sd may only change on the clk right after a consumed word.
      if (epd_sd != prev_sd && !prev_ready) n_unstable++;
      if (pending) begin
        check("sd_word", int'(epd_sd), exp_word);
        pending          = 1'b0;
        idx++;
        pix_if.pix_data  = SD_WIDTH'(idx + 1);
        pix_if.pix_valid = (idx != drop);
      end
      if (pix_if.pix_ready) begin
        n_ready++;
        if (sdce0) n_ce_bad++;
        exp_word = pix_if.pix_valid ? int'(pix_if.pix_data) : 0;
        pending  = 1'b1;
      end
      prev_sd    = epd_sd;
      prev_ready = pix_if.pix_ready;

      if (frame_done) n_done++;
      if (!sdce0)     n_sdce_low++;
      if (!gdsp)      n_gdsp_low++;
      if (sdle)       n_sdle_high++;

      // Low gdoe runs that end while still busy are the gaps between frames.
      if (!gdoe) run++;
      else begin
        if (run > 0 && busy && n_done > 0) begin
          n_gap_runs++;
          if (run != FRAME_GAP * CLK_DIV) n_gap_bad++;
        end
        run = 0;
      end

      if (rst_at > 0 && n_ready == rst_at && !rst_fired) begin
        rst       = 1'b1;
        rst_fired = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int nf;
    int drop;
    bit extra;
    int exp_ready;
    int exp_done;
    int exp_gaps;
    bit exp_ur;
  } vec_t;

  vec_t vecs [5];
  int   quiet_done, quiet_busy;

  initial begin
    //          nf  drop extra ready done gaps underrun
    vecs[0] = '{1,  -1,  0,    12,   1,   0,   1'b0};
    vecs[1] = '{3,  -1,  1,    36,   3,   2,   1'b0};
    vecs[2] = '{1,   5,  0,    12,   1,   0,   UR_EN};
    vecs[3] = '{2,  -1,  0,    24,   2,   1,   1'b0};
    vecs[4] = '{0,  -1,  0,     0,   0,   0,   1'b0};

    pix_if.pix_data  = '0;
    pix_if.pix_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].nf, vecs[i].drop, vecs[i].extra, 0,
               (vecs[i].nf == 0) ? 100 : vecs[i].nf * 260 + 400);
      check($sformatf("v%0d_busy_seen", i), int'(busy_seen), int'(vecs[i].nf != 0));
      check($sformatf("v%0d_busy_next_clk", i), int'(busy_first), int'(vecs[i].nf != 0));
      if (vecs[i].nf != 0) check($sformatf("v%0d_timeout", i), int'(timed_out), 0);
      check($sformatf("v%0d_ready", i), n_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_frame_done", i), n_done, vecs[i].exp_done);
      check($sformatf("v%0d_gap_runs", i), n_gap_runs, vecs[i].exp_gaps);
      check($sformatf("v%0d_gap_len_bad", i), n_gap_bad, 0);
      check($sformatf("v%0d_sd_unstable", i), n_unstable, 0);
      check($sformatf("v%0d_sdce0_hi_on_ready", i), n_ce_bad, 0);
      check($sformatf("v%0d_sdce0_low_clks", i), n_sdce_low, vecs[i].exp_ready * CLK_DIV);
      check($sformatf("v%0d_gdsp_low_clks", i), n_gdsp_low,
            vecs[i].nf * (PRESCAN - 15) * CLK_DIV);
      check($sformatf("v%0d_sdle_high_clks", i), n_sdle_high,
            vecs[i].nf * V_ACTIVE * 2 * CLK_DIV);
      check($sformatf("v%0d_underrun", i), int'(underrun), int'(vecs[i].exp_ur));
      check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      check($sformatf("v%0d_idle_gdoe", i), int'(gdoe), 0);
      repeat (3) @(negedge clk);
    end

    // Reset during row 1 data: the frame is abandoned without a frame_done.
    run_scan(1, -1, 1'b0, H_ACTIVE + 2, 600);
    check("rst_mid_fired", int'(timed_out), 0);
    check("rst_mid_no_done", n_done, 0);
    quiet_done = 0;
    quiet_busy = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_done) quiet_done++;
      if (busy)       quiet_busy++;
    end
    check("post_rst_frame_done", quiet_done, 0);
    check("post_rst_busy", quiet_busy, 0);

    // A fresh start after the reset runs one complete frame.
    run_scan(1, -1, 1'b0, 0, 660);
    check("recover_timeout", int'(timed_out), 0);
    check("recover_ready", n_ready, H_ACTIVE * V_ACTIVE);
    check("recover_frame_done", n_done, 1);
    check("recover_sd_unstable", n_unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_epd_scan_ctrl
